// File: rtl/tdp_ram_sync.sv
// Single-clock true dual-port RAM with byte lanes, 1- or 2-cycle read latency,
// read-first/write-first selection and deterministic same-address write merging.
module tdp_ram_sync #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int BYTE_WIDTH  = 8,
  parameter int RD_LATENCY  = 1,
  parameter int RW_MODE     = 0,
  parameter int WR_PRIORITY = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wren_a,
  input  logic                             rden_a,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be_a,
  input  logic [ADDR_WIDTH-1:0]            addr_a,
  input  logic [DATA_WIDTH-1:0]            din_a,
  output logic [DATA_WIDTH-1:0]            dout_a,
  output logic                             dvalid_a,
  input  logic                             wren_b,
  input  logic                             rden_b,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be_b,
  input  logic [ADDR_WIDTH-1:0]            addr_b,
  input  logic [DATA_WIDTH-1:0]            din_b,
  output logic [DATA_WIDTH-1:0]            dout_b,
  output logic                             dvalid_b,
  output logic                             wr_collision
);

  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  generate
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
      $fatal(1, "tdp_ram_sync: RD_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
      $fatal(1, "tdp_ram_sync: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
  endgenerate

  // Ports are renamed to winner/loser once so the lane logic is priority-agnostic.
  logic                  win_wr, los_wr;
  logic [NB-1:0]         win_be, los_be;
  logic [ADDR_WIDTH-1:0] win_addr, los_addr;
  logic [DATA_WIDTH-1:0] win_din, los_din;

  assign win_wr   = ~rst & ((WR_PRIORITY == 1) ? wren_b : wren_a);
  assign los_wr   = ~rst & ((WR_PRIORITY == 1) ? wren_a : wren_b);
  assign win_be   = (WR_PRIORITY == 1) ? be_b   : be_a;
  assign los_be   = (WR_PRIORITY == 1) ? be_a   : be_b;
  assign win_addr = (WR_PRIORITY == 1) ? addr_b : addr_a;
  assign los_addr = (WR_PRIORITY == 1) ? addr_a : addr_b;
  assign win_din  = (WR_PRIORITY == 1) ? din_b  : din_a;
  assign los_din  = (WR_PRIORITY == 1) ? din_a  : din_b;

  logic [DATA_WIDTH-1:0] rd_a_word, rd_b_word;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      logic [BYTE_WIDTH-1:0] mem [DEPTH];
      logic [BYTE_WIDTH-1:0] q_a_reg, q_b_reg;
      logic [BYTE_WIDTH-1:0] new_a, new_b;
      logic                  win_we, los_we;

      assign win_we = win_wr & win_be[gi];
      assign los_we = los_wr & los_be[gi];

      // Post-write view of the addressed lane, used only in write-first mode.
      always_comb begin
        new_a = mem[addr_a];
        new_b = mem[addr_b];
        if (los_we && los_addr == addr_a) new_a = los_din[gi*BYTE_WIDTH +: BYTE_WIDTH];
        if (win_we && win_addr == addr_a) new_a = win_din[gi*BYTE_WIDTH +: BYTE_WIDTH];
        if (los_we && los_addr == addr_b) new_b = los_din[gi*BYTE_WIDTH +: BYTE_WIDTH];
        if (win_we && win_addr == addr_b) new_b = win_din[gi*BYTE_WIDTH +: BYTE_WIDTH];
      end

      // Winner is written last so it overrides the loser on a shared address.
      always_ff @(posedge clk) begin
        if (los_we) mem[los_addr] <= los_din[gi*BYTE_WIDTH +: BYTE_WIDTH];
        if (win_we) mem[win_addr] <= win_din[gi*BYTE_WIDTH +: BYTE_WIDTH];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          q_a_reg <= '0;
          q_b_reg <= '0;
        end else begin
          if (rden_a) q_a_reg <= (RW_MODE == 1) ? new_a : mem[addr_a];
          if (rden_b) q_b_reg <= (RW_MODE == 1) ? new_b : mem[addr_b];
        end
      end

      assign rd_a_word[gi*BYTE_WIDTH +: BYTE_WIDTH] = q_a_reg;
      assign rd_b_word[gi*BYTE_WIDTH +: BYTE_WIDTH] = q_b_reg;
    end
  endgenerate

  logic vld1_a_reg, vld1_b_reg;
  logic coll_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld1_a_reg <= 1'b0;
      vld1_b_reg <= 1'b0;
      coll_reg   <= 1'b0;
    end else begin
      vld1_a_reg <= rden_a;
      vld1_b_reg <= rden_b;
      coll_reg   <= wren_a & wren_b & (addr_a == addr_b) & (|(be_a & be_b));
    end
  end

  assign wr_collision = coll_reg;

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] dout_a_reg, dout_b_reg;
      logic                  vld2_a_reg, vld2_b_reg;

      // Second stage only loads on a fresh word so dout holds between reads.
      always_ff @(posedge clk) begin
        if (rst) begin
          dout_a_reg <= '0;
          dout_b_reg <= '0;
          vld2_a_reg <= 1'b0;
          vld2_b_reg <= 1'b0;
        end else begin
          vld2_a_reg <= vld1_a_reg;
          vld2_b_reg <= vld1_b_reg;
          if (vld1_a_reg) dout_a_reg <= rd_a_word;
          if (vld1_b_reg) dout_b_reg <= rd_b_word;
        end
      end

      assign dout_a   = dout_a_reg;
      assign dout_b   = dout_b_reg;
      assign dvalid_a = vld2_a_reg;
      assign dvalid_b = vld2_b_reg;
    end else begin : g_lat1
      assign dout_a   = rd_a_word;
      assign dout_b   = rd_b_word;
      assign dvalid_a = vld1_a_reg;
      assign dvalid_b = vld1_b_reg;
    end
  endgenerate

endmodule
